// File: rtl/ice40_spram_model.sv
// Behavioural model of the iCE40UP single-port RAM: nibble write mask, registered read port,
// standby/sleep/power-off controls. Reset touches only the read register, never the array.
module ice40_spram_model #(
  parameter int unsigned ADDR_WIDTH        = 14,
  parameter int unsigned DATA_WIDTH        = 16,
  parameter bit          CLEAR_ON_POWEROFF = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   datain,
  input  logic [DATA_WIDTH/4-1:0] maskwren,
  input  logic                    wren,
  input  logic                    chipselect,
  input  logic                    standby,
  input  logic                    sleep,
  input  logic                    poweroff,
  output logic [DATA_WIDTH-1:0]   dataout
);

  localparam int unsigned Depth      = 2 ** ADDR_WIDTH;
  localparam int unsigned NumNibbles = DATA_WIDTH / 4;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  en;
  logic                  wr_en;
  logic                  rd_en;
  logic                  word_valid;

  // poweroff is active-low: 1 means powered
  assign en    = chipselect & ~standby & ~sleep & poweroff;
  assign wr_en = en & wren & resetn;
  assign rd_en = en & ~wren;

  generate
    if (CLEAR_ON_POWEROFF) begin : g_clear
      // One valid bit per word; dropping them all makes the array read back as zero.
      logic [Depth-1:0] valid_q;

      always_ff @(posedge clk) begin
        if (!poweroff) begin
          valid_q <= '0;
        end else if (wr_en && (|maskwren)) begin
          valid_q[address] <= 1'b1;
        end
      end

      assign word_valid = valid_q[address];
    end else begin : g_keep
      assign word_valid = 1'b1;
    end
  endgenerate

  // Writing to an invalid word zero-fills the unmasked nibbles so stale data never reappears.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NumNibbles; k++) begin
        if (maskwren[k] || !word_valid) begin
          mem_q[address][4*k +: 4] <= maskwren[k] ? datain[4*k +: 4] : 4'h0;
        end
      end
    end
  end

  assign rdata = word_valid ? mem_q[address] : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_q <= '0;
    end else if (!poweroff || sleep) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= rdata;
    end
  end

  assign dataout = dout_q;

endmodule

// File: tb/tb_ice40_spram_model.sv
// Bench for ice40_spram_model: two instances form a 32-bit word; a bench-side memory model
// predicts dataout each cycle through an expectation queue.
module tb_ice40_spram_model;

  logic        clk = 1'b0;
  logic        resetn;
  logic [13:0] addr;
  logic [31:0] din;
  logic [7:0]  mask;
  logic        wren, cs, sb, sl, pwr;
  logic [15:0] dout_lo, dout_hi;

  always #5 clk = ~clk;

  ice40_spram_model u_lo (
    .clk(clk), .resetn(resetn), .address(addr), .datain(din[15:0]), .maskwren(mask[3:0]),
    .wren(wren), .chipselect(cs), .standby(sb), .sleep(sl), .poweroff(pwr), .dataout(dout_lo)
  );

  ice40_spram_model u_hi (
    .clk(clk), .resetn(resetn), .address(addr), .datain(din[31:16]), .maskwren(mask[7:4]),
    .wren(wren), .chipselect(cs), .standby(sb), .sleep(sl), .poweroff(pwr), .dataout(dout_hi)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model [int];
  logic [31:0] exp_q [$];
  logic [31:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [13:0] a);
    return model.exists(int'(a)) ? model[int'(a)] : 32'h0;
  endfunction

  // One clock of stimulus; the predicted dataout is queued, then checked after the edge.
  task automatic step(input string tag, input logic c, input logic w, input logic [13:0] a,
                      input logic [31:0] d, input logic [7:0] m, input logic s_b,
                      input logic s_l, input logic p);
    logic [31:0] nd;
    logic [31:0] word;
    logic        e;
    @(negedge clk);
    cs = c; wren = w; addr = a; din = d; mask = m; sb = s_b; sl = s_l; pwr = p;
    e = c & ~s_b & ~s_l & p;
    if (!p || s_l)     nd = 32'h0;
    else if (e && !w)  nd = rd_model(a);
    else               nd = exp_dout;
    exp_q.push_back(nd);
    @(posedge clk);
    #1;
    if (!p) begin
      model.delete();
    end else if (e && w) begin
      word = rd_model(a);
      for (int k = 0; k < 8; k++) if (m[k]) word[4*k +: 4] = d[4*k +: 4];
      model[int'(a)] = word;
    end
    exp_dout = nd;
    check(tag, {dout_hi, dout_lo}, exp_q.pop_front());
  endtask

  task automatic wr(input string tag, input logic [13:0] a, input logic [31:0] d,
                    input logic [7:0] m);
    step(tag, 1'b1, 1'b1, a, d, m, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rd(input string tag, input logic [13:0] a);
    step(tag, 1'b1, 1'b0, a, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    resetn = 1'b0; addr = '0; din = '0; mask = '0; wren = 1'b0; cs = 1'b0;
    sb = 1'b0; sl = 1'b0; pwr = 1'b0; exp_dout = 32'h0;
    #1;
    check("reset_dout", {dout_hi, dout_lo}, 32'h0);
    // Power-off during reset gives a known all-zero array.
    step("init_off0", 1'b0, 1'b0, 14'h0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    step("init_off1", 1'b0, 1'b0, 14'h0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    pwr    = 1'b1;

    // Full write then read, including read-after-write on the next cycle.
    wr("full_wr", 14'h0000, 32'h0000A5C3, 8'h0F);
    rd("full_rd", 14'h0000);
    check("full_rd_const", {dout_hi, dout_lo}, 32'h0000A5C3);

    // Nibble mask on the top address.
    wr("nib_wr0", 14'h3FFF, 32'h00001234, 8'h0F);
    wr("nib_wr1", 14'h3FFF, 32'h0000FFFF, 8'h05);
    rd("nib_rd", 14'h3FFF);
    check("nib_const", {dout_hi, dout_lo}, 32'h00001F3F);

    // Byte strobe 0b0010 mapped to mask pairs onto a zeroed word.
    wr("byte_wr", 14'h0020, 32'hDEADBEEF, 8'h0C);
    rd("byte_rd", 14'h0020);
    check("byte_const", {dout_hi, dout_lo}, 32'h0000BE00);

    // Zero mask writes nothing.
    wr("mask0_wr", 14'h0000, 32'hFFFFFFFF, 8'h00);
    rd("mask0_rd", 14'h0000);

    // Standby during a read holds dataout; chipselect low holds as well.
    step("standby_rd", 1'b1, 1'b0, 14'h3FFF, 32'h0, 8'h0, 1'b1, 1'b0, 1'b1);
    step("nocs_rd", 1'b0, 1'b0, 14'h0020, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);

    // Sleep forces zero and ignores writes; contents survive.
    step("sleep0", 1'b1, 1'b0, 14'h0000, 32'h0, 8'h0, 1'b0, 1'b1, 1'b1);
    step("sleep_wr", 1'b1, 1'b1, 14'h0000, 32'h12345678, 8'hFF, 1'b0, 1'b1, 1'b1);
    rd("wake_rd", 14'h0000);
    check("wake_const", {dout_hi, dout_lo}, 32'h0000A5C3);

    // Power-off clears the array.
    wr("pwr_wr", 14'h0007, 32'h00005555, 8'h0F);
    rd("pwr_rd_pre", 14'h0007);
    for (int i = 0; i < 4; i++)
      step("pwr_off", 1'b1, 1'b0, 14'h0007, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    rd("pwr_rd_post", 14'h0007);
    check("pwr_const", {dout_hi, dout_lo}, 32'h0);

    // Asynchronous reset mid-cycle clears dataout but keeps contents.
    wr("rst_wr", 14'h0100, 32'hCAFEBEEF, 8'hFF);
    rd("rst_rd_pre", 14'h0100);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async", {dout_hi, dout_lo}, 32'h0);
    exp_dout = 32'h0;
    @(negedge clk);
    resetn = 1'b1;
    rd("rst_rd_post", 14'h0100);
    check("rst_const", {dout_hi, dout_lo}, 32'hCAFEBEEF);

    // Random mix over a small address window.
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 1) == 0)
        wr("rand_wr", 14'h0200 + 14'($urandom_range(0, 7)), $urandom, 8'($urandom));
      else
        rd("rand_rd", 14'h0200 + 14'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ice40_spram_model.md
Name: ice40_spram_model

Overview:
- Synthesizable behavioural model of the iCE40UP 256 Kbit single-port RAM: 16384 words x 16 bits, nibble write mask, registered read port, low-power controls.
- Instantiated in pairs to build 32-bit, 64 KB CPU scratch memories, with byte strobes mapped to mask-bit pairs.
- Used in simulation and for FPGA targets without the hard SPRAM macro.

Parameters:
- ADDR_WIDTH, 14, word address width (depth = 2**ADDR_WIDTH).
- DATA_WIDTH, 16, word width; must be a multiple of 4 (one mask bit per nibble).
- CLEAR_ON_POWEROFF, 1, when 1 array contents are zeroed while powered off; when 0 they are retained.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- address  in  ADDR_WIDTH  word address.
- datain  in  DATA_WIDTH  write data.
- maskwren  in  DATA_WIDTH/4  nibble write enables; bit k covers datain[4k+3:4k].
- wren  in  1  write (1) / read (0) select.
- chipselect  in  1  access enable.
- standby  in  1  1 = standby, accesses ignored, dataout held.
- sleep  in  1  1 = sleep, accesses ignored, dataout forced 0.
- poweroff  in  1  active-low power: 1 = powered, 0 = off.
- dataout  out  DATA_WIDTH  registered read data.

Behaviour:
- Reset: resetn=0 asynchronously clears dataout to 0. Array contents are not affected by reset.
- Access enable: en = chipselect & !standby & !sleep & poweroff, sampled on the rising edge of clk.
- Write (en & wren):
  - For each k with maskwren[k]=1, mem[address] nibble k <= datain nibble k; other nibbles are unchanged.
  - maskwren=0 writes nothing.
  - dataout holds its previous value.
- Read (en & !wren): dataout <= mem[address]. Data is valid one cycle after the request edge (latency 1).
- No access (chipselect=0 or standby=1): dataout holds.
- Sleep:
  - Power-state priority is poweroff, then sleep, then standby.
  - While sleep=1 (and poweroff=1), dataout is 0 on the next edge and stays 0; array contents are retained.
  - On exit, the first access is allowed on the next edge.
- Power off:
  - While poweroff=0, dataout is 0 and accesses are ignored.
  - If CLEAR_ON_POWEROFF=1, the whole array reads 0 after power returns. Implement with a valid-bit/epoch scheme or a sequential clear that completes before the first permitted access; the interface behaviour must be identical either way.
- Read-after-write to the same address on consecutive cycles returns the new data (write completes at its edge).
- Address wrap: address is exactly ADDR_WIDTH bits; no out-of-range case exists.
- Out-of-range arithmetic: none; all widths are exact.
- Reset mid-operation:
  - An in-flight read result is discarded and dataout=0.
  - A write on the same edge as reset release is performed only if resetn=1 at that edge.
- Initial array content at power-up simulation is 0.

Test Plan:
- Full write then read: addr 0x0000 wren=1 mask=0xF data=0xA5C3; next cycle read addr 0 -> dataout=0xA5C3 one cycle after read edge.
- Nibble mask: mem[0x3FFF]=0x1234; write data 0xFFFF mask=0b0101 -> read returns 0x1F3F.
- Byte-pair use: two instances driven with wstrb mapping; 32-bit write 0xDEADBEEF with wstrb=0b0010 onto zeroed word -> reads 0x0000BE00.
- Low power:
  - standby=1 during a read -> dataout unchanged.
  - sleep=1 -> dataout=0, then sleep=0 and read -> previous contents intact.
- Power off (CLEAR_ON_POWEROFF=1): write 0x5555 at addr 7, poweroff=0 for 4 cycles, restore -> read addr 7 returns 0.
- Async reset: assert resetn=0 mid-cycle after read of 0xBEEF -> dataout=0 immediately; after release, read returns 0xBEEF (contents kept).
